// File: rtl/rc_err_monitor.sv
// Compares two fixed-point RC model outputs sample-by-sample. It accumulates
// peak error and tolerance violations, and flags when the reference has converged.
module rc_err_monitor #(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 8,
  parameter int MAX_DIFF  = 1,
  parameter int SETTLE_N  = 16,
  parameter int CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    valid,
  input  logic signed [WIDTH-1:0] v_a,
  input  logic signed [WIDTH-1:0] v_b,
  output logic                    busy,
  output logic                    settled,
  output logic                    fail,
  output logic [WIDTH:0]          err_max,
  output logic [CNT_W-1:0]        viol_cnt,
  output logic [CNT_W-1:0]        first_viol,
  output logic [CNT_W-1:0]        sample_cnt
);

  if (SETTLE_N < 1 || SETTLE_N > (2 ** CNT_W) - 1) begin : g_bad_settle
    $error("rc_err_monitor: SETTLE_N out of range for CNT_W");
  end
  if (FRAC_BITS < 0 || FRAC_BITS >= WIDTH) begin : g_bad_frac
    $error("rc_err_monitor: FRAC_BITS must lie inside WIDTH");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_SETTLED
  } state_t;

  localparam logic [WIDTH:0]   LP_TOL     = (WIDTH + 1)'(MAX_DIFF);
  localparam logic [CNT_W-1:0] LP_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LP_SETTLE  = CNT_W'(SETTLE_N);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH:0]   r_err_max;
  logic [CNT_W-1:0] r_viol_cnt;
  logic [CNT_W-1:0] r_first_viol;
  logic [CNT_W-1:0] r_sample_cnt;
  logic [CNT_W-1:0] r_stable_cnt;
  logic [WIDTH-1:0] r_prev_a;
  logic             r_first;

  logic             w_accept;
  logic             w_eval;
  logic             w_viol;
  logic             w_step_ok;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_absd;
  logic [WIDTH:0]   w_step;
  logic [WIDTH:0]   w_abs_step;
  logic [CNT_W-1:0] w_stable_nxt;

  // Sign-extending by one bit makes both subtractions overflow-free, and the
  // most-negative WIDTH+1 value is unreachable, so negation is exact.
  assign w_diff     = {v_a[WIDTH-1], v_a} - {v_b[WIDTH-1], v_b};
  assign w_absd     = w_diff[WIDTH] ? (~w_diff + 1'b1) : w_diff;
  assign w_step     = {v_a[WIDTH-1], v_a} - {r_prev_a[WIDTH-1], r_prev_a};
  assign w_abs_step = w_step[WIDTH] ? (~w_step + 1'b1) : w_step;

  assign w_viol    = (w_absd > LP_TOL);
  assign w_step_ok = (w_abs_step <= LP_TOL);

  // start takes priority: a coincident sample is dropped, not counted.
  assign w_accept = valid && !start && (r_state != ST_IDLE);
  assign w_eval   = w_accept && (r_state == ST_RUN) && !r_first;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_stable_nxt = r_stable_cnt;
    if (w_eval) begin
      if (!w_step_ok)                       w_stable_nxt = '0;
      else if (r_stable_cnt != LP_CNT_MAX)  w_stable_nxt = r_stable_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:    if (start) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (start)                                     w_state_nxt = ST_RUN;
        else if (w_eval && (w_stable_nxt == LP_SETTLE)) w_state_nxt = ST_SETTLED;
      end
      ST_SETTLED: if (start) w_state_nxt = ST_RUN;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_max    <= '0;
      r_viol_cnt   <= '0;
      r_first_viol <= '1;
      r_sample_cnt <= '0;
    end else if (start) begin
      r_err_max    <= '0;
      r_viol_cnt   <= '0;
      r_first_viol <= '1;
      r_sample_cnt <= '0;
    end else if (w_accept) begin
      if (r_sample_cnt != LP_CNT_MAX) r_sample_cnt <= r_sample_cnt + 1'b1;
      if (w_absd > r_err_max)         r_err_max    <= w_absd;
      if (w_viol) begin
        if (r_viol_cnt != LP_CNT_MAX) r_viol_cnt <= r_viol_cnt + 1'b1;
        // Index of this sample is the pre-increment count; it is already
        // all-ones once the sample counter has saturated.
        if (r_viol_cnt == '0)         r_first_viol <= r_sample_cnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stable_cnt <= '0;
      r_prev_a     <= '0;
      r_first      <= 1'b1;
    end else if (start) begin
      r_stable_cnt <= '0;
      r_prev_a     <= '0;
      r_first      <= 1'b1;
    end else if (w_accept && (r_state == ST_RUN)) begin
      r_prev_a     <= v_a;
      r_first      <= 1'b0;
      r_stable_cnt <= w_stable_nxt;
    end
  end

  assign busy       = (r_state == ST_RUN);
  assign settled    = (r_state == ST_SETTLED);
  assign fail       = (r_viol_cnt != '0);
  assign err_max    = r_err_max;
  assign viol_cnt   = r_viol_cnt;
  assign first_viol = r_first_viol;
  assign sample_cnt = r_sample_cnt;

endmodule
